// File: rtl/gf_2m_digit_mult.sv
// Digit-serial GF(2^m) multiplier with MUL / SQR / MAC modes and valid/ready handshakes.
// Consumes D bits of operand a per clock, MSB first; the field polynomial is a run-time input.
module gf_2m_digit_mult #(
  parameter int m = 8,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [m-1:0] a,
  input  logic [m-1:0] b,
  input  logic [m-1:0] c,
  input  logic [m-1:0] p,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [m-1:0] y,
  output logic         busy
);

  localparam int N  = (m + D - 1) / D;
  localparam int AW = N * D;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] OP_SQR = 2'b01;
  localparam logic [1:0] OP_MAC = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  a_q, a_d;
  logic [m-1:0]   b_q, b_d;
  logic [m-1:0]   c_q, c_d;
  logic [m-1:0]   p_q, p_d;
  logic [m-1:0]   s_q, s_d;
  logic [m-1:0]   y_q, y_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           accept;
  logic [m-1:0]   s_step;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign y         = y_q;
  assign accept    = in_valid && in_ready;

  // D chained shift/reduce/add steps over the top D bits of the padded operand.
  always_comb begin
    s_step = s_q;
    // NOTE: blocking assignments here build a combinational chain; each
    // iteration sees the value written by the previous one in the same pass.
    for (int j = 0; j < D; j++) begin
      s_step = {s_step[m-2:0], 1'b0}
             ^ (s_step[m-1] ? p_q : '0)
             ^ (a_q[AW-1-j] ? b_q : '0);
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    p_d     = p_q;
    s_d     = s_q;
    y_d     = y_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: ;
      BUSY: begin
        s_d   = s_step;
        a_d   = a_q << D;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          y_d     = s_step ^ c_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An accept in DONE overrides the retire-to-IDLE transition above.
    if (accept) begin
      a_d     = AW'(a);
      b_d     = (op == OP_SQR) ? a : b;
      c_d     = (op == OP_MAC) ? c : '0;
      p_d     = p;
      s_d     = '0;
      cnt_d   = CW'(N);
      state_d = BUSY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      p_q     <= '0;
      s_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      p_q     <= p_d;
      s_q     <= s_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_gf_2m_digit_mult.sv
// Bench for gf_2m_digit_mult: directed m=4 vectors plus five m=8 instances (D = 1,2,3,5,8)
// sharing stimulus, each scoreboarded against a polynomial-multiply-then-reduce model.
module tb_gf_2m_digit_mult;

  localparam int NI = 5;
  localparam int DV [NI] = '{1, 2, 3, 5, 8};

  logic clk = 1'b0;
  logic rst_n, rst4_n;

  // m = 4, D = 1 instance
  logic       iv4, ir4, ov4, or4, busy4;
  logic [1:0] op4;
  logic [3:0] a4, b4, c4, p4, y4;

  // m = 8 instances, shared inputs
  logic           iv8, or8;
  logic [1:0]     op8;
  logic [7:0]     a8, b8, c8, p8;
  logic [NI-1:0]  ir8, ov8, busy8;
  logic [7:0]     y8 [NI];

  int   checks   = 0;
  int   failures = 0;
  logic drain_chk = 1'b0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full polynomial product, then reduction by x^mm + p from the top bit down.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z,
                                        input logic [7:0] p, input int mm);
    logic [15:0] prod;
    logic [15:0] poly;
    prod = '0;
    for (int i = 0; i < mm; i++)
      if (x[i]) prod ^= 16'(z) << i;
    poly = 16'(p) | (16'd1 << mm);
    for (int i = 2 * mm - 2; i >= mm; i--)
      if (prod[i]) prod ^= poly << (i - mm);
    return prod[7:0];
  endfunction

  function automatic logic [7:0] expect_y(input logic [1:0] op, input logic [7:0] x,
                                          input logic [7:0] z, input logic [7:0] cc,
                                          input logic [7:0] p, input int mm);
    logic [7:0] r;
    r = gf_mul(x, (op == 2'b01) ? x : z, p, mm);
    if (op == 2'b10) r ^= cc;
    return r;
  endfunction

  gf_2m_digit_mult #(.m(4), .D(1)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .in_valid(iv4), .in_ready(ir4), .op(op4),
    .a(a4), .b(b4), .c(c4), .p(p4), .out_valid(ov4), .out_ready(or4),
    .y(y4), .busy(busy4)
  );

  for (genvar gi = 0; gi < NI; gi++) begin : g_d8
    gf_2m_digit_mult #(.m(8), .D(DV[gi])) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8[gi]), .op(op8),
      .a(a8), .b(b8), .c(c8), .p(p8), .out_valid(ov8[gi]), .out_ready(or8),
      .y(y8[gi]), .busy(busy8[gi])
    );

    logic [7:0] exp_q [$];

    // Inputs change just after posedge, so at negedge they describe the coming edge.
    always @(negedge clk) begin
      if (rst_n) begin
        if (ov8[gi]) begin
          check($sformatf("sb_has_entry_d%0d", DV[gi]), 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            check($sformatf("y_d%0d", DV[gi]), 32'(y8[gi]), 32'(exp_q[0]));
            if (or8) exp_q.delete(0);
          end
        end
        if (iv8 && ir8[gi]) exp_q.push_back(expect_y(op8, a8, b8, c8, p8, 8));
      end
    end

    always @(posedge drain_chk)
      check($sformatf("drain_d%0d", DV[gi]), 32'(exp_q.size()), 32'd0);
  end

  task automatic wait_ov4(output int lat);
    lat = 0;
    while (!ov4 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Called at posedge+1 with the m=4 instance idle and or4 = 1.
  task automatic run4(input logic [1:0] op, input logic [3:0] x, input logic [3:0] z,
                      input logic [3:0] cc, input logic [3:0] exp, input string name);
    int lat;
    op4 = op; a4 = x; b4 = z; c4 = cc; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    wait_ov4(lat);
    check({name, "_lat"}, 32'(lat), 32'd4);
    check({name, "_y"}, 32'(y4), 32'(exp));
    check({name, "_model"}, 32'(y4), 32'(expect_y(op, 8'(x), 8'(z), 8'(cc), 8'(p4), 4)));
    @(posedge clk); #1;
    check({name, "_retired"}, 32'(ov4), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int lat8 [NI];

    rst_n = 1'b0; rst4_n = 1'b0;
    iv4 = 1'b0; or4 = 1'b1; op4 = 2'b00; a4 = '0; b4 = '0; c4 = '0; p4 = 4'h3;
    iv8 = 1'b0; or8 = 1'b1; op8 = 2'b00; a8 = '0; b8 = '0; c8 = '0; p8 = 8'h1B;

    #12;
    check("rst_ov4",   32'(ov4),   32'd0);
    check("rst_ir4",   32'(ir4),   32'd1);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_y4",    32'(y4),    32'd0);
    check("rst_ov8",   32'(ov8),   32'd0);
    check("rst_ir8",   32'(ir8),   32'h1F);
    check("rst_y8_d1", 32'(y8[0]), 32'd0);
    check("rst_y8_d8", 32'(y8[4]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; rst4_n = 1'b1;

    check("model_pin_aes", 32'(gf_mul(8'h57, 8'h83, 8'h1B, 8)), 32'hC1);
    check("model_pin_m4",  32'(gf_mul(8'h07, 8'h0B, 8'h03, 4)), 32'h4);
    check("model_pin_sqr", 32'(expect_y(2'b01, 8'h09, 8'h0F, 8'h00, 8'h03, 4)), 32'hD);

    // Directed m=4 vectors
    run4(2'b00, 4'h2, 4'h8, 4'h0, 4'h3, "mul_2x8");
    run4(2'b00, 4'h7, 4'hB, 4'h0, 4'h4, "mul_7xB");
    run4(2'b01, 4'h9, 4'hF, 4'h0, 4'hD, "sqr_9");
    run4(2'b10, 4'h2, 4'h8, 4'h5, 4'h6, "mac_2x8_5");
    run4(2'b11, 4'h2, 4'h8, 4'h0, 4'h3, "rsvd_2x8");

    // Same AES product on every m=8 digit size; c must be ignored for MUL
    op8 = 2'b00; a8 = 8'h57; b8 = 8'h83; c8 = 8'hAA; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    for (int k = 0; k < NI; k++) lat8[k] = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++)
        if (ov8[k] && lat8[k] == 0) lat8[k] = cyc;
    end
    for (int k = 0; k < NI; k++) begin
      check($sformatf("aes_lat_d%0d", DV[k]), 32'(lat8[k]), 32'((8 + DV[k] - 1) / DV[k]));
      check($sformatf("aes_y_d%0d", DV[k]), 32'(y8[k]), 32'hC1);
    end

    // Back-pressure then back-to-back accept on the retire edge
    or4 = 1'b0; op4 = 2'b00; a4 = 4'h2; b4 = 4'h8; c4 = 4'h0; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    wait_ov4(lat);
    check("bp_lat", 32'(lat), 32'd4);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_ov",  32'(ov4), 32'd1);
      check("bp_y",   32'(y4),  32'h3);
      check("bp_ir",  32'(ir4), 32'd0);
    end
    or4 = 1'b1; a4 = 4'h7; b4 = 4'hB; iv4 = 1'b1;
    #1;
    check("b2b_ir_comb", 32'(ir4), 32'd1);
    @(posedge clk); #1;
    iv4 = 1'b0;
    check("b2b_ov_drop", 32'(ov4),   32'd0);
    check("b2b_busy",    32'(busy4), 32'd1);
    wait_ov4(lat);
    check("b2b_lat", 32'(lat), 32'd4);
    check("b2b_y",   32'(y4),  32'h4);
    @(posedge clk); #1;
    check("b2b_idle_ir", 32'(ir4), 32'd1);

    // Asynchronous reset while BUSY
    op4 = 2'b00; a4 = 4'h7; b4 = 4'hB; iv4 = 1'b1;
    @(posedge clk); #1;
    iv4 = 1'b0;
    @(posedge clk); #2;
    check("mid_busy", 32'(busy4), 32'd1);
    rst4_n = 1'b0;
    #1;
    check("mid_rst_ov",   32'(ov4),   32'd0);
    check("mid_rst_y",    32'(y4),    32'd0);
    check("mid_rst_ir",   32'(ir4),   32'd1);
    check("mid_rst_busy", 32'(busy4), 32'd0);
    @(posedge clk); #1;
    rst4_n = 1'b1;
    run4(2'b01, 4'h9, 4'hF, 4'h0, 4'hD, "post_rst_sqr");

    // Random traffic on the m=8 instances, checked by the per-instance scoreboards
    repeat (20000) begin
      @(posedge clk); #1;
      iv8 = 1'($urandom_range(0, 1));
      or8 = ($urandom_range(0, 3) != 0);
      op8 = 2'($urandom_range(0, 3));
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      c8  = 8'($urandom);
      p8  = 8'($urandom);
    end
    @(posedge clk); #1;
    iv8 = 1'b0; or8 = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    drain_chk = 1'b1;
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gf_2m_digit_mult.md
Name: gf_2m_digit_mult

Overview:
Sequential digit-serial GF(2^m) multiplier with valid/ready handshakes and three operating modes: multiply, square and multiply-accumulate. It processes D bits of operand a per cycle, MSB first, using the same shift/reduce/add recurrence as the combinational GF(2^m) multiplier. It trades latency for area in wide fields such as ECC or Reed-Solomon datapaths, where a full m×m array is too large. The field polynomial is a run-time input, so one instance serves any field of degree m.

Parameters:
m, 8, field degree and operand width in bits (m >= 2)
D, 1, digit size in bits processed per cycle (1 <= D <= m)

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request present
in_ready  output  1  block can accept a request this cycle
op  input  2  00 = MUL (a·b), 01 = SQR (a·a, b ignored), 10 = MAC (a·b ^ c), 11 = reserved, executed as MUL
a  input  m  operand A
b  input  m  operand B
c  input  m  addend for MAC
p  input  m  field polynomial without its x^m term (bit i is the coefficient of x^i)
out_valid  output  1  result available on y
out_ready  input  1  consumer accepts the result
y  output  m  result
busy  output  1  high while in state BUSY

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state = IDLE; in_ready = 1; out_valid = 0; busy = 0; y = 0; all internal registers = 0.
- Reset asserted mid-operation aborts the operation immediately. No result is produced.
- N = ceil(m/D). Operand a is zero-padded at the MSB to N·D bits. Leading zeros leave the accumulator at 0, so no partial-digit special case is needed.
- Accept: a handshake occurs on a rising edge where in_valid && in_ready.
  - On that edge: register a, b_eff, p and c_eff.
  - b_eff = a when op = SQR, else b.
  - c_eff = c when op = MAC, else 0.
  - Clear the accumulator s, load the digit counter with N, and go to BUSY.
- BUSY: each edge applies D inner steps, taking bits of padded a from MSB downward. One step is:
  - s = (s[m-1] ? p : 0) ^ {s[m-2:0], 1'b0} ^ (a_bit ? b_eff : 0)
  - The counter decrements each edge. The edge that completes digit N sets y = s_final ^ c_eff and goes to DONE.
- Latency: out_valid rises exactly N clock edges after the accept edge.
- DONE:
  - out_valid = 1. y is held stable until an edge with out_ready = 1.
  - On that edge, with in_valid = 0: go to IDLE and drop out_valid.
- Ready rule: in_ready = (state == IDLE) || (state == DONE && out_ready). This is combinational from out_ready, which gives back-to-back operation without a bubble.
- Simultaneous events: in DONE with out_ready && in_valid on the same edge, the result retires and the new request is accepted. The next state is BUSY and out_valid drops for N cycles.
- In BUSY: in_ready = 0. Input changes have no effect because operands are sampled only on accept.
- y holds its last value after retiring.
- Results are bit-identical to combinational multiplication over the same m and p, for every legal D.
- D = m gives single-cycle compute (N = 1).
- Arithmetic is purely XOR/AND; no carries. Output width is exactly m.

Test Plan:
1. m=4, D=1, p=4'h3: MUL a=4'h2, b=4'h8 -> y=4'h3, out_valid 4 cycles after accept. Then MUL a=4'h7, b=4'hB -> y=4'h4.
2. m=4, D=1, p=4'h3: SQR a=4'h9 with b=4'hF (ignored) -> y=4'hD. MAC a=4'h2, b=4'h8, c=4'h5 -> y=4'h6. op=11 with a=4'h2, b=4'h8 -> y=4'h3.
3. m=8, D=3, p=8'h1B: MUL a=8'h57, b=8'h83 -> y=8'hC1, out_valid exactly 3 cycles after accept. Repeat with D=1 (8 cycles) and D=8 (1 cycle): identical y.
4. Back-pressure and back-to-back:
   - Hold out_ready=0 for 5 cycles: y and out_valid stable, in_ready=0.
   - Raise out_ready together with in_valid carrying a new request: result retires, new request is accepted on the same edge, and its result appears N cycles later.
5. Reset mid-operation: assert rst_n=0 asynchronously during BUSY -> immediately state IDLE, out_valid=0, y=0, in_ready=1. A fresh request after release returns the correct product.
6. Randomised: 10,000 random a, b, c, op, p for m=8 with D in {1, 2, 3, 5, 8} -> y matches a bit-level software model of the shift/reduce recurrence. No request is lost or duplicated under random in_valid/out_ready toggling.
